// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the hazard stall controller and the forwarding unit:
// opcode[6:2] constants for RV32I, the stall FSM state type, and the register
// use/write predicates for an instruction's major opcode.
package hazard_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // Width of the remaining-penalty counter; sized for a load-use penalty of up to 3.
  localparam int REM_W = 2;

  typedef enum logic {
    ST_RUN,
    ST_LSTALL
  } stall_state_t;

  function automatic logic is_load(input logic [4:0] op);
    return op == OP_LOAD;
  endfunction

  function automatic logic uses_rs1(input logic [4:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM});
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_REG};
  endfunction

  // Opcode-level only; rd==x0 filtering is applied by the caller.
  function automatic logic writes_rd(input logic [4:0] op);
    return !(op inside {OP_BRANCH, OP_STORE, OP_SYSTEM});
  endfunction

endpackage

// File: rtl/inst_reg_use_decode.sv
// inst_reg_use_decode
// Pure combinational decode of one instruction word into its register fields
// and use/write flags.
// Ports:
//   inst      in   32  instruction word
//   rs1       out  5   source register 1 field
//   rs2       out  5   source register 2 field
//   rd        out  5   destination register field
//   load      out  1   instruction is a load
//   rs1_used  out  1   instruction reads rs1
//   rs2_used  out  1   instruction reads rs2
//   rd_written out 1   instruction writes a non-zero rd
import hazard_pkg::*;

module inst_reg_use_decode (
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        load,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        rd_written
);

  logic [4:0] op;
  logic       unused_bits;

  assign op  = inst[6:2];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];

  assign load     = is_load(op);
  assign rs1_used = uses_rs1(op);
  assign rs2_used = uses_rs2(op);
  // A write to x0 is discarded, so it can never be the source of a hazard.
  assign rd_written = writes_rd(op) && (inst[11:7] != 5'd0);

  // Funct and size bits play no part in hazard detection.
  assign unused_bits = ^{inst[31:25], inst[14:12], inst[1:0]};

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Resolves the hazards that bypassing cannot: load-use dependencies, taken
// control transfers resolved in X, and data-memory wait states.
// Ports:
//   clock       in   1      system clock
//   reset_n     in   1      synchronous active-low reset
//   inst_d      in   32     D-stage instruction word
//   inst_x      in   32     X-stage instruction word
//   br_taken_x  in   1      X-stage branch/JAL/JALR taken this cycle
//   dmem_req    in   1      M-stage data-memory access outstanding
//   dmem_ready  in   1      data memory completes the access this cycle
//   stall_f     out  1      hold PC and F/D register
//   stall_d     out  1      hold D/X source
//   bubble_x    out  1      load NOP into D/X next edge
//   flush_d     out  1      load NOP into F/D next edge
//   freeze      out  1      hold every pipeline register
//   stall_count out  CNT_W  saturating count of freeze/stall_d/flush_d cycles
import hazard_pkg::*;

module hazard_stall_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      inst_d,
  input  logic [31:0]      inst_x,
  input  logic             br_taken_x,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_x,
  output logic             flush_d,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [4:0] x_rs1, x_rs2, x_rd;
  logic       d_load, d_rs1_used, d_rs2_used, d_rd_written;
  logic       x_load, x_rs1_used, x_rs2_used, x_rd_written;
  logic       unused_decode;
  logic       lu;
  logic       mem_wait;

  stall_state_t       state;
  logic [REM_W-1:0]   rem;

  inst_reg_use_decode u_dec_d (
    .inst       (inst_d),
    .rs1        (d_rs1),
    .rs2        (d_rs2),
    .rd         (d_rd),
    .load       (d_load),
    .rs1_used   (d_rs1_used),
    .rs2_used   (d_rs2_used),
    .rd_written (d_rd_written)
  );

  inst_reg_use_decode u_dec_x (
    .inst       (inst_x),
    .rs1        (x_rs1),
    .rs2        (x_rs2),
    .rd         (x_rd),
    .load       (x_load),
    .rs1_used   (x_rs1_used),
    .rs2_used   (x_rs2_used),
    .rd_written (x_rd_written)
  );

  // Only the consumer side of D and the producer side of X matter here.
  assign unused_decode = ^{d_rd, d_load, d_rd_written,
                           x_rs1, x_rs2, x_rs1_used, x_rs2_used};

  assign lu = x_load && x_rd_written &&
              ((d_rs1_used && (d_rs1 == x_rd)) || (d_rs2_used && (d_rs2 == x_rd)));

  assign mem_wait = dmem_req && !dmem_ready;

  // A memory wait overrides everything; a pending load-use penalty beats a
  // taken branch because X already holds a bubble and cannot redirect.
  always_comb begin
    freeze   = mem_wait;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    bubble_x = 1'b0;
    flush_d  = 1'b0;
    if (!mem_wait) begin
      if (state == ST_LSTALL) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_x = 1'b1;
      end else if (br_taken_x) begin
        flush_d  = 1'b1;
        bubble_x = 1'b1;
      end else if (lu) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_x = 1'b1;
      end
    end
  end

  // Penalty FSM: the first stall cycle is issued from RUN, so LSTALL only
  // covers the remaining LOAD_LAT-1 cycles. Everything holds while frozen.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_RUN;
      rem   <= '0;
    end else if (!mem_wait) begin
      case (state)
        ST_RUN: begin
          if (!br_taken_x && lu && (LOAD_LAT > 1)) begin
            state <= ST_LSTALL;
            rem   <= REM_W'(LOAD_LAT - 1);
          end
        end
        ST_LSTALL: begin
          if (rem == REM_W'(1)) begin
            state <= ST_RUN;
            rem   <= '0;
          end else begin
            rem <= rem - REM_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
          rem   <= '0;
        end
      endcase
    end
  end

  // Saturating performance counter of lost cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if ((freeze || stall_d || flush_d) && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Drives four controller instances (penalties 1, 2, 3 and a narrow-counter
// copy) with the same inputs and compares them against a cycle-level model
// that tracks "stall cycles still owed" and a saturating lost-cycle count.
module tb_hazard_stall_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] LW5 = 32'h0000A283;
  localparam logic [31:0] ADD = 32'h00728333;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] inst_d, inst_x;
  logic        br_taken_x, dmem_req, dmem_ready;

  logic [3:0]  sf, sd, bx, fd, fz;
  logic [31:0] cnt0, cnt1, cnt2;
  logic [2:0]  cnt3;

  int     checkCount = 0;
  int     errorCount = 0;
  int     latTab[4]  = '{1, 2, 3, 1};
  longint maxTab[4]  = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd7};
  string  nameTab[4] = '{"lat1", "lat2", "lat3", "sat"};
  int     owed[4];
  longint lostModel[4];

  always #5 clock = ~clock;

  hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .inst_d(inst_d), .inst_x(inst_x),
    .br_taken_x(br_taken_x), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_f(sf[0]), .stall_d(sd[0]), .bubble_x(bx[0]), .flush_d(fd[0]),
    .freeze(fz[0]), .stall_count(cnt0));

  hazard_stall_ctrl #(.LOAD_LAT(2), .CNT_W(32)) u_lat2 (
    .clock(clock), .reset_n(reset_n), .inst_d(inst_d), .inst_x(inst_x),
    .br_taken_x(br_taken_x), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_f(sf[1]), .stall_d(sd[1]), .bubble_x(bx[1]), .flush_d(fd[1]),
    .freeze(fz[1]), .stall_count(cnt1));

  hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(32)) u_lat3 (
    .clock(clock), .reset_n(reset_n), .inst_d(inst_d), .inst_x(inst_x),
    .br_taken_x(br_taken_x), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_f(sf[2]), .stall_d(sd[2]), .bubble_x(bx[2]), .flush_d(fd[2]),
    .freeze(fz[2]), .stall_count(cnt2));

  hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(3)) u_sat (
    .clock(clock), .reset_n(reset_n), .inst_d(inst_d), .inst_x(inst_x),
    .br_taken_x(br_taken_x), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_f(sf[3]), .stall_d(sd[3]), .bubble_x(bx[3]), .flush_d(fd[3]),
    .freeze(fz[3]), .stall_count(cnt3));

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Whether an instruction reads register r, straight from the opcode tables.
  function automatic bit refReads(input logic [31:0] inst, input logic [4:0] r);
    logic [4:0] op;
    bit r1, r2;
    op = inst[6:2];
    r1 = !(op inside {5'b01101, 5'b00101, 5'b11011, 5'b11100});
    r2 = op inside {5'b11000, 5'b01000, 5'b01100};
    return (r1 && inst[19:15] == r) || (r2 && inst[24:20] == r);
  endfunction

  function automatic bit refLoadUse(input logic [31:0] ix, input logic [31:0] id);
    return (ix[6:2] == 5'b00000) && (ix[11:7] != 5'd0) && refReads(id, ix[11:7]);
  endfunction

  function automatic logic [4:0] getCtl(input int i);
    return {fz[i], sf[i], sd[i], bx[i], fd[i]};
  endfunction

  function automatic logic [63:0] getCnt(input int i);
    case (i)
      0:       return {32'd0, cnt0};
      1:       return {32'd0, cnt1};
      2:       return {32'd0, cnt2};
      default: return {61'd0, cnt3};
    endcase
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    logic [4:0]  ops[10] = '{5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                              5'b01101, 5'b00101, 5'b00100, 5'b01100, 5'b11100};
    w        = $urandom();
    w[1:0]   = 2'b11;
    w[6:2]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  // One clock cycle: drive, check the combinational outputs and registered
  // count mid-cycle, advance the model, then step past the next edge.
  task automatic applyStimulus(input logic rn, input logic [31:0] ix, input logic [31:0] id,
                               input logic br, input logic req, input logic rdy);
    bit         frz, lu;
    logic [4:0] expCtl;
    reset_n    = rn;
    inst_x     = ix;
    inst_d     = id;
    br_taken_x = br;
    dmem_req   = req;
    dmem_ready = rdy;
    #3;
    frz = req && !rdy;
    lu  = refLoadUse(ix, id);
    for (int i = 0; i < 4; i++) begin
      if (frz)             expCtl = 5'b10000;
      else if (owed[i] > 0) expCtl = 5'b01110;
      else if (br)         expCtl = 5'b00011;
      else if (lu)         expCtl = 5'b01110;
      else                 expCtl = 5'b00000;
      checkOutput({nameTab[i], ".ctl"}, {59'd0, getCtl(i)}, {59'd0, expCtl});
      checkOutput({nameTab[i], ".cnt"}, getCnt(i), lostModel[i]);
      if (!rn) begin
        owed[i]      = 0;
        lostModel[i] = 0;
      end else begin
        if ((expCtl[4] || expCtl[2] || expCtl[0]) && lostModel[i] < maxTab[i])
          lostModel[i]++;
        if (!frz) begin
          if (owed[i] > 0)     owed[i]--;
          else if (!br && lu)  owed[i] = latTab[i] - 1;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] ix, id;
    logic        br, req, rdy, rn;

    reset_n = 1'b0; inst_x = NOP; inst_d = NOP;
    br_taken_x = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      owed[i] = 0;
      lostModel[i] = 0;
    end
    $display("[TB] reset applied, starting directed cycles");

    applyStimulus(1, NOP, NOP, 0, 0, 0);
    applyStimulus(1, NOP, NOP, 0, 0, 0);

    // lw x5 then add x6,x5,x7: penalty length per instance
    applyStimulus(1, LW5, ADD, 0, 0, 0);
    repeat (4) applyStimulus(1, NOP, ADD, 0, 0, 0);
    checkOutput("lu.cnt_lat1", getCnt(0), 64'd1);
    checkOutput("lu.cnt_lat2", getCnt(1), 64'd2);
    checkOutput("lu.cnt_lat3", getCnt(2), 64'd3);

    // lw x0 against a reader of x0, and lw x5 against lui x5: no stall
    applyStimulus(1, 32'h0000A003, 32'h00000033, 0, 0, 0);
    applyStimulus(1, LW5, 32'h123452B7, 0, 0, 0);
    checkOutput("nolu.cnt_lat1", getCnt(0), 64'd1);

    // load-use squashed by a taken branch
    applyStimulus(1, LW5, ADD, 1, 0, 0);
    applyStimulus(1, NOP, NOP, 0, 0, 0);
    checkOutput("br.cnt_lat3", getCnt(2), 64'd4);

    // memory wait in the middle of a 3-cycle penalty
    applyStimulus(1, LW5, ADD, 0, 0, 0);
    repeat (4) applyStimulus(1, NOP, ADD, 0, 1, 0);
    repeat (3) applyStimulus(1, NOP, ADD, 0, 0, 0);
    checkOutput("frz.cnt_lat3", getCnt(2), 64'd11);
    checkOutput("frz.cnt_sat", getCnt(3), 64'd7);

    // reset in the middle of a penalty
    applyStimulus(1, LW5, ADD, 0, 0, 0);
    applyStimulus(0, NOP, ADD, 0, 0, 0);
    applyStimulus(1, NOP, ADD, 0, 0, 0);
    checkOutput("rst.cnt_lat3", getCnt(2), 64'd0);
    checkOutput("rst.ctl_lat3", {59'd0, getCtl(2)}, 64'd0);

    $display("[TB] starting random cycles");
    for (int n = 0; n < 1500; n++) begin
      ix  = randInst();
      id  = randInst();
      br  = ($urandom_range(0, 5) == 0);
      req = ($urandom_range(0, 3) == 0);
      rdy = 1'($urandom_range(0, 1));
      rn  = !($urandom_range(0, 80) == 0);
      applyStimulus(rn, ix, id, br, req, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
